// File: rtl/fp_add_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_pkg
//  Description : Shared constants, helper functions and types for the
//                pipelined floating-point adder (fp_add_pipe).
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_add_pkg;

    // Widest packed float any builder below has to produce.
    localparam int C_MAX_FP_W = 128;

    // Largest (all-ones) biased exponent for a given exponent width.
    function automatic int exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // IEEE-style exponent bias for a given exponent width.
    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Quiet NaN {0, all-ones exponent, 1, zeros}; callers size-cast the result.
    function automatic logic [C_MAX_FP_W-1:0] qnan(input int exp_w, input int man_w);
        logic [C_MAX_FP_W-1:0] one;
        one = {{(C_MAX_FP_W-1){1'b0}}, 1'b1};
        return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
    endfunction

    // Status flags reported alongside each result.
    typedef struct packed {
        logic inexact;
        logic overflow;
        logic zero;
    } fp_flags_t;

endpackage
`default_nettype wire

// File: rtl/fp_add_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_pipe_if
//  Description : Operand/result handshake bundle for fp_add_pipe. The
//                master drives operands and accepts results; the slave is
//                the adder itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_add_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int C_FP_W = 1 + EXP_W + MAN_W;

    logic              in_valid;
    logic              in_ready;
    logic [C_FP_W-1:0] in_a;
    logic [C_FP_W-1:0] in_b;
    logic              in_sub;
    logic              out_valid;
    logic              out_ready;
    logic [C_FP_W-1:0] out_result;
    logic              out_inexact;
    logic              out_overflow;
    logic              out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_result, out_inexact, out_overflow, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_result, out_inexact, out_overflow, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc
//  Description : Parametrised leading-zero counter. An all-zero input
//                reports WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic [WIDTH-1:0] i_vec,
    output logic      [CNT_W-1:0] o_cnt
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        o_cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) o_cnt = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_pipe
//  Description : 3-stage pipelined floating-point adder/subtractor
//                (align / add / normalise+pack) with valid/ready flow
//                control. Denormals are read as zero; results that would
//                be denormal flush to signed zero.
//  Options     : FP_ADD_ROUND_NEAREST_EN - round-to-nearest-even in the
//                normalise stage; otherwise results are truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_pipe
    import fp_add_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fp_add_pipe_if.slave      bus
);

    localparam int C_FP_W  = 1 + EXP_W + MAN_W;
    localparam int C_MW    = MAN_W + 4;            // {hidden, frac, guard, round, sticky}
    localparam int C_CNT_W = $clog2(C_MW + 1);
    localparam int C_SX_W  = EXP_W + 2;            // exponent workspace with borrow bit
    localparam logic [EXP_W-1:0]  C_EXP_ONES = EXP_W'(exp_max(EXP_W));
    localparam logic [C_FP_W-1:0] C_QNAN     = C_FP_W'(qnan(EXP_W, MAN_W));

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [C_MW-1:0]  mant_ext;
    } operand_t;

    typedef struct packed {
        logic              sign;
        logic              eff_sub;
        logic [EXP_W-1:0]  exp;
        logic [C_MW-1:0]   mx;
        logic [C_MW-1:0]   my;
        logic              special;
        logic [C_FP_W-1:0] special_val;
    } s1_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [C_MW:0]     sum;
        logic              special;
        logic [C_FP_W-1:0] special_val;
    } s2_t;

    typedef struct packed {
        logic [C_FP_W-1:0] result;
        fp_flags_t         flags;
    } s3_t;

    logic r_s1_valid, r_s2_valid, r_s3_valid;
    s1_t  r_s1, w_s1;
    s2_t  r_s2, w_s2;
    s3_t  r_s3, w_s3;
    logic w_s1_en, w_s2_en, w_s3_en;

    // A stage loads when it is empty or its content moves on this cycle.
    assign w_s3_en      = !r_s3_valid || bus.out_ready;
    assign w_s2_en      = !r_s2_valid || w_s3_en;
    assign w_s1_en      = !r_s1_valid || w_s2_en;
    assign bus.in_ready = w_s1_en;

    // ---------------- S1: unpack, swap, align ----------------
    operand_t         w_a, w_b, w_x, w_y;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [EXP_W-1:0] w_diff;
    logic [C_MW-1:0]  w_y_sh, w_lost_mask;

    // Unpack, order by magnitude and shift the smaller operand with sticky.
    always_comb begin
        w_a.sign     = bus.in_a[C_FP_W-1];
        w_a.exp      = bus.in_a[C_FP_W-2 -: EXP_W];
        w_a.mant_ext = (w_a.exp == '0) ? '0 : {1'b1, bus.in_a[MAN_W-1:0], 3'b000};
        w_b.sign     = bus.in_b[C_FP_W-1] ^ bus.in_sub;
        w_b.exp      = bus.in_b[C_FP_W-2 -: EXP_W];
        w_b.mant_ext = (w_b.exp == '0) ? '0 : {1'b1, bus.in_b[MAN_W-1:0], 3'b000};

        w_a_nan = (w_a.exp == C_EXP_ONES) && (bus.in_a[MAN_W-1:0] != '0);
        w_b_nan = (w_b.exp == C_EXP_ONES) && (bus.in_b[MAN_W-1:0] != '0);
        w_a_inf = (w_a.exp == C_EXP_ONES) && (bus.in_a[MAN_W-1:0] == '0);
        w_b_inf = (w_b.exp == C_EXP_ONES) && (bus.in_b[MAN_W-1:0] == '0);

        if ({w_b.exp, w_b.mant_ext} > {w_a.exp, w_a.mant_ext}) begin
            w_x = w_b;
            w_y = w_a;
        end else begin
            w_x = w_a;
            w_y = w_b;
        end

        w_diff      = w_x.exp - w_y.exp;
        w_y_sh      = '0;
        w_lost_mask = '0;
        if (32'(w_diff) > MAN_W + 3) begin
            // Everything shifts out: only the sticky bit survives.
            w_y_sh[0] = |w_y.mant_ext;
        end else begin
            w_lost_mask = ~({C_MW{1'b1}} << w_diff);
            w_y_sh      = w_y.mant_ext >> w_diff;
            w_y_sh[0]   = w_y_sh[0] | (|(w_y.mant_ext & w_lost_mask));
        end

        w_s1             = '0;
        w_s1.sign        = w_x.sign;
        w_s1.eff_sub     = w_x.sign ^ w_y.sign;
        w_s1.exp         = w_x.exp;
        w_s1.mx          = w_x.mant_ext;
        w_s1.my          = w_y_sh;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a.sign != w_b.sign))) begin
            w_s1.special     = 1'b1;
            w_s1.special_val = C_QNAN;
        end else if (w_a_inf) begin
            w_s1.special     = 1'b1;
            w_s1.special_val = {w_a.sign, C_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_s1.special     = 1'b1;
            w_s1.special_val = {w_b.sign, C_EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // S1 register: capture aligned operands on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) r_s1 <= w_s1;
        end
    end

    // ---------------- S2: mantissa add/sub ----------------
    // |X| >= |Y| after the swap, so the subtraction never goes negative.
    always_comb begin
        w_s2             = '0;
        w_s2.sign        = r_s1.sign;
        w_s2.exp         = r_s1.exp;
        w_s2.special     = r_s1.special;
        w_s2.special_val = r_s1.special_val;
        if (r_s1.eff_sub) w_s2.sum = {1'b0, r_s1.mx} - {1'b0, r_s1.my};
        else              w_s2.sum = {1'b0, r_s1.mx} + {1'b0, r_s1.my};
    end

    // S2 register: hold the raw sum until S3 can take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2 <= w_s2;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [C_CNT_W-1:0] w_lzc;
    logic [C_MW-1:0]    w_norm;
    logic [C_SX_W-1:0]  w_exp_n, w_exp_r;
    logic [MAN_W:0]     w_mant_r;
    logic               w_inexact;

    fp_lzc #(.WIDTH(C_MW), .CNT_W(C_CNT_W)) u_lzc (
        .i_vec (r_s2.sum[C_MW-1:0]),
        .o_cnt (w_lzc)
    );

    // Normalise the sum, apply the rounding mode and resolve zero/overflow/special.
    always_comb begin
        if (r_s2.sum[C_MW]) begin
            w_norm    = r_s2.sum[C_MW:1];
            w_norm[0] = r_s2.sum[1] | r_s2.sum[0];
            w_exp_n   = {2'b00, r_s2.exp} + C_SX_W'(1);
        end else begin
            w_norm  = r_s2.sum[C_MW-1:0] << w_lzc;
            w_exp_n = {2'b00, r_s2.exp} - {{(C_SX_W-C_CNT_W){1'b0}}, w_lzc};
        end
        w_inexact = |w_norm[2:0];

`ifdef FP_ADD_ROUND_NEAREST_EN
        // Round half to even; a carry out of the mantissa means 1.000 at exp+1.
        begin
            logic w_rnd_inc, w_rnd_carry;
            w_rnd_inc = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
            {w_rnd_carry, w_mant_r} = {1'b0, w_norm[C_MW-1:3]} + {{(MAN_W+1){1'b0}}, w_rnd_inc};
            w_exp_r = w_exp_n + {{(C_SX_W-1){1'b0}}, w_rnd_carry};
        end
`else
        w_mant_r = w_norm[C_MW-1:3];
        w_exp_r  = w_exp_n;
`endif

        w_s3 = '0;
        if (r_s2.special) begin
            w_s3.result = r_s2.special_val;
        end else if (r_s2.sum == '0) begin
            w_s3.flags.zero = 1'b1;
        end else if (w_exp_n[C_SX_W-1] || (w_exp_n == '0)) begin
            w_s3.result        = {r_s2.sign, {(C_FP_W-1){1'b0}}};
            w_s3.flags.zero    = 1'b1;
            w_s3.flags.inexact = w_inexact;
        end else if (w_exp_r >= {2'b00, C_EXP_ONES}) begin
            w_s3.result         = {r_s2.sign, C_EXP_ONES, {MAN_W{1'b0}}};
            w_s3.flags.overflow = 1'b1;
            w_s3.flags.inexact  = w_inexact;
        end else begin
            w_s3.result        = {r_s2.sign, w_exp_r[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
            w_s3.flags.inexact = w_inexact;
        end
    end

    // S3 register: the packed result presented to the downstream consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3       <= '0;
        end else if (w_s3_en) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) r_s3 <= w_s3;
        end
    end

    assign bus.out_valid    = r_s3_valid;
    assign bus.out_result   = r_s3.result;
    assign bus.out_inexact  = r_s3.flags.inexact;
    assign bus.out_overflow = r_s3.flags.overflow;
    assign bus.out_zero     = r_s3.flags.zero;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_pipe
//  Description : Directed self-checking bench for fp_add_pipe (binary32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] F1 = 32'h3F80_0000;   // 1.0
    localparam logic [31:0] F2 = 32'h4000_0000;   // 2.0
    localparam logic [31:0] F3 = 32'h4040_0000;   // 3.0

    logic [31:0] bp_a   [5] = '{F1, F1, F2, F3, F3};
    logic [31:0] bp_b   [5] = '{F1, F2, F2, F2, F3};
    logic [31:0] bp_exp [5] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                32'h40A0_0000, 32'h40C0_0000};
    logic [31:0] got    [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] flags();
        return {29'd0, bus.out_inexact, bus.out_overflow, bus.out_zero};
    endfunction

    // One operation into an idle pipe; checks latency, result and {inexact,overflow,zero}.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_res, input logic [2:0] exp_flg);
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = sub;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_result"}, bus.out_result, exp_res);
        chk({tag, "_flags"}, flags(), {29'd0, exp_flg});
    endtask

    initial begin
        int idx;
        int n;
        int spurious;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_flags", flags(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed arithmetic
        run_op("add_1_2",       F1,            F2,            1'b0, 32'h4040_0000, 3'b000);
        run_op("sub_1_1",       F1,            F1,            1'b1, 32'h0000_0000, 3'b001);
        run_op("ovf_max_max",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010);
        run_op("trunc_tiny",    F1,            32'h3080_0000, 1'b0, 32'h3F80_0000, 3'b100);
        run_op("sub_3_1",       F3,            F1,            1'b1, 32'h4000_0000, 3'b000);
        run_op("sub_lzc2",      F1,            32'h3F40_0000, 1'b1, 32'h3E80_0000, 3'b000);
        run_op("neg_add",       32'hBF80_0000, 32'hC000_0000, 1'b0, 32'hC040_0000, 3'b000);
        run_op("underflow",     32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h8000_0000, 3'b001);
        run_op("nan_prop",      32'h7FC1_2345, F1,            1'b0, 32'h7FC0_0000, 3'b000);
        run_op("inf_plus_1",    32'h7F80_0000, F1,            1'b0, 32'h7F80_0000, 3'b000);

        // Backpressure: offer 5 ops with the consumer stalled
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_sub    = 1'b0;
            if (idx < 5) begin
                bus.in_valid = 1'b1;
                bus.in_a     = bp_a[idx];
                bus.in_b     = bp_b[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && bus.in_ready) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);

        // Release the consumer and drain everything in order
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (idx < 5) begin
                bus.in_valid = 1'b1;
                bus.in_a     = bp_a[idx];
                bus.in_b     = bp_b[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid) begin
                got[n] = bus.out_result;
                n++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
        end
        bus.in_valid = 1'b0;
        chk("bp_count", 32'(n), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("bp_res%0d", i), got[i], bp_exp[i]);

        // Reset with two operations in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = F1;
        bus.in_b      = F2;
        @(negedge clk);
        bus.in_a      = F2;
        bus.in_b      = F2;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk("mid_out_valid_pre", {31'd0, bus.out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid_async", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_out_result_async", bus.out_result, 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) spurious++;
        end
        chk("mid_no_stale_output", 32'(spurious), 32'd0);
        run_op("post_rst_inf_sub_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b000);
        run_op("post_rst_add_1_2",     F1,            F2,            1'b0, 32'h4040_0000, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, 3-stage pipelined floating-point adder/subtractor: align, add/sub, normalise/pack.
- Generalises the existing combinational mantissa adder to any exponent/mantissa width.
- Adds full normalisation (carry right-shift and leading-zero left-shift), special-value handling and valid/ready flow control.
- Sits between the operand-fetch stage and the result writeback in the FP datapath.

Parameters:
- EXP_W, 8, exponent field width in bits.
- MAN_W, 23, stored fraction width in bits; the hidden bit is implicit.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- in_a  in  1+EXP_W+MAN_W  operand A, packed {sign, exp, frac}
- in_b  in  1+EXP_W+MAN_W  operand B, same format
- in_sub  in  1  1 = compute A-B; 0 = compute A+B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_result  out  1+EXP_W+MAN_W  packed result
- out_inexact  out  1  nonzero bits were discarded during alignment or normalisation
- out_overflow  out  1  result exponent saturated to infinity
- out_zero  out  1  result is zero

Behaviour:
- Reset (async assert, sync deassert use): all stage valid bits cleared; out_valid=0; out_result=0; all flags=0; in_ready=1 on the cycle after reset releases.
- Handshake: a transfer happens when valid && ready on that side.
- Each stage holds its data until the next stage accepts it.
- A stage advances when its successor is empty or is advancing.
- in_ready = !s1_valid || s1_advance. This is combinational from out_ready through the stages; no skid buffer.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle when out_ready=1.
- Ordering: results are returned strictly in input order. Data is never dropped or duplicated under any stall pattern.
- S1 (align):
  - Effective sign of B = sign_B ^ in_sub.
  - Denormal inputs (exp=0) are treated as zero.
  - Swap operands so that |X| >= |Y|, comparing {exp, frac}.
  - Right-shift Y's {1, frac} by the exponent difference, keeping guard and round bits plus a sticky OR of the shifted-out bits.
  - If the difference exceeds MAN_W+3, Y collapses to sticky only.
- S2 (add): MAN_W+4-bit mantissa add or subtract, by sign_X ^ sign_Y_eff. Carry is kept. Result sign = sign_X.
- S3 (normalise/pack):
  - Carry set: shift right by 1 and increment the exponent; the shifted-out bit ORs into sticky.
  - Otherwise: shift left by the leading-zero count (LZC) and subtract LZC from the exponent.
  - If the exponent underflows to <= 0, flush to signed zero with out_zero=1.
  - If the exponent reaches all-ones, output infinity (frac=0) with out_overflow=1.
  - Exact cancellation (mantissa sum = 0) gives +0 with out_zero=1.
  - Rounding without the optional feature: truncate. out_inexact = guard|round|sticky.
- Specials:
  - Any input exp all-ones: inf+inf with like signs gives inf.
  - inf-inf (effective unlike signs) gives quiet NaN {0, all-ones, 1, zeros}.
  - A NaN input propagates as the same quiet NaN. Flags are 0 except when set by the rules above.
- Reset mid-operation: in-flight operations are discarded; no partial output.

Optional Feature:
- Macro: FP_ADD_ROUND_NEAREST_EN.
- Defined: S3 applies round-to-nearest-even using guard/round/sticky.
  - A mantissa overflow caused by rounding renormalises (exponent +1) and may produce overflow to infinity.
  - out_inexact has the same definition.
- Undefined: truncation only, with no rounding incrementer in S3.
- Latency is 3 cycles in both configurations.

Decomposition:
- Package fp_add_pkg holds:
  - EXP_MAX and BIAS constants as functions of the widths;
  - a typedef for unpacked operands {sign, exp, mant_ext};
  - typedefs for the stage payload structs;
  - the quiet-NaN constant builder.
- One sub-module, fp_lzc: a parametrised leading-zero counter of width MAN_W+4, instantiated in S3.

Test Plan:
- 0x3F800000 + 0x40000000, in_sub=0, out_ready=1 -> 3 cycles later out_result=0x40400000; all flags 0.
- 0x3F800000 with in_sub=1 on itself (1.0-1.0) -> out_result=0x00000000, out_zero=1.
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, out_overflow=1.
- 0x3F800000 + 0x30800000 -> 0x3F800000, out_inexact=1 (truncation build).
- Backpressure:
  - Stimulus: 5 back-to-back inputs while out_ready=0.
  - Expect: in_ready drops after 3 accepted.
  - Then release out_ready: the 5 results appear in order with no loss.
- Reset:
  - Stimulus: assert rst_n=0 with 2 ops in flight.
  - Expect: out_valid=0 immediately (asynchronous).
  - After release, the first new op returns a correct result after 3 cycles.
  - Also: 0x7F800000 - 0x7F800000 -> 0x7FC00000.
